cpu_branch_resolve: RTL and testbench

- Resolves branch and jump instructions for the KH32 fetch stage.
- Captures the branch word while fetch stalls, and evaluates the condition and target over two cycles.
- Presents PC_temp/PC_jump_flag in exactly the cycle fetch samples them (fetch's third stall cycle).
- Sits between the IF register outputs (IR, PC_IF), the ALU flag register and the register-file read port.

---
 rtl/cpu_branch_resolve_pkg.sv | 20 ++
 rtl/cpu_branch_resolve_if.sv | 12 +
 rtl/cpu_branch_resolve_cond.sv | 25 ++
 rtl/cpu_branch_resolve.sv | 79 +++++++
 tb/tb_cpu_branch_resolve.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_branch_resolve_pkg.sv
// cpukh_branch_pkg: opcodes, condition codes, flag indices and FSM states for the branch resolver
package cpukh_branch_pkg;
  localparam logic [3:0] OP_BRANCH = 4'b0100;
  localparam logic [3:0] OP_JUMP = 4'b0101;
  localparam logic [3:0] COND_NEVER = 4'd0;
  localparam logic [3:0] COND_ALWAYS = 4'd1;
  localparam logic [3:0] COND_EQ = 4'd2;
  localparam logic [3:0] COND_NE = 4'd3;
  localparam logic [3:0] COND_LT = 4'd4;
  localparam logic [3:0] COND_GE = 4'd5;
  localparam logic [3:0] COND_CS = 4'd6;
  localparam logic [3:0] COND_CC = 4'd7;
  localparam logic [3:0] COND_MI = 4'd8;
  localparam logic [3:0] COND_PL = 4'd9;
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
  typedef enum logic [1:0] {IDLE, EVAL, RESOLVE} state_t;
endpackage

// File: rtl/cpu_branch_resolve_if.sv
// cpu_branch_resolve_if: fetch-side signals shared between the fetch stage and the branch resolver
interface cpu_branch_resolve_if #(parameter int ADDR_W = 32);
  logic en;
  logic LOAD_happened;
  logic [31:0] IR;
  logic [ADDR_W-1:0] PC_IF;
  logic [ADDR_W-1:0] PC_temp;
  logic PC_jump_flag;
  logic busy;
  modport master (output en, LOAD_happened, IR, PC_IF, input PC_temp, PC_jump_flag, busy);
  modport slave (input en, LOAD_happened, IR, PC_IF, output PC_temp, PC_jump_flag, busy);
endinterface

// File: rtl/cpu_branch_resolve_cond.sv
// cpu_branch_cond: combinational branch condition evaluator over {Z,N,C,V}
module cpu_branch_cond
  import cpukh_branch_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       taken
);
  logic z, n, c, v;
  assign z = flags[FLAG_Z];
  assign n = flags[FLAG_N];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];
  always_comb begin
    taken = cond == COND_ALWAYS ? 1'b1 :
            cond == COND_EQ     ? z :
            cond == COND_NE     ? !z :
            cond == COND_LT     ? (n ^ v) :
            cond == COND_GE     ? !(n ^ v) :
            cond == COND_CS     ? c :
            cond == COND_CC     ? !c :
            cond == COND_MI     ? n :
            cond == COND_PL     ? !n : 1'b0;
  end
endmodule

// File: rtl/cpu_branch_resolve.sv
// cpu_branch_resolve: two-cycle branch/jump resolver feeding PC_temp/PC_jump_flag to fetch
// Optional BRANCH_STATS_EN adds saturating taken/not-taken counters.
module cpu_branch_resolve
  import cpukh_branch_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int OFF_W = 24,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  cpu_branch_resolve_if.slave fetch,
  input  logic [3:0]         alu_flags,
  output logic [RADDR_W-1:0] jr_addr,
  input  logic [ADDR_W-1:0]  rs_data
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]        stat_taken,
  output logic [31:0]        stat_not_taken
`endif
);
  state_t state, state_nx;
  logic [31:0] ir_q;
  logic [ADDR_W-1:0] base_q, rs_q, pc_temp_q, target;
  logic flag_q, cond_taken, taken, is_ctl, is_jump, capture, fire;
  assign is_ctl = fetch.IR[31:28] == OP_BRANCH || fetch.IR[31:28] == OP_JUMP;
  assign capture = state == IDLE && fetch.en && !fetch.LOAD_happened && is_ctl;
  assign fire = state == EVAL && fetch.en && !fetch.LOAD_happened;
  assign is_jump = ir_q[31:28] == OP_JUMP;
  assign jr_addr = fetch.IR[RADDR_W-1:0];
  cpu_branch_cond u_cond (.cond(ir_q[27:24]), .flags(alu_flags), .taken(cond_taken));
  always_comb begin
    target = is_jump ? (ir_q[27] ? rs_q : ADDR_W'(ir_q[26:0]))
                     : base_q + {{(ADDR_W-OFF_W){ir_q[OFF_W-1]}}, ir_q[OFF_W-1:0]};
    taken = is_jump ? 1'b1 : cond_taken;
  end
  // Load stalls win over en: fetch restarts its count, so we must too.
  always_comb begin
    state_nx = fetch.LOAD_happened ? IDLE :
               !fetch.en           ? state :
               state == IDLE       ? (is_ctl ? EVAL : IDLE) :
               state == EVAL       ? RESOLVE : IDLE;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      ir_q <= '0;
      base_q <= '0;
      rs_q <= '0;
      pc_temp_q <= '0;
      flag_q <= 1'b0;
    end else begin
      if (capture) begin
        ir_q <= fetch.IR;
        base_q <= fetch.PC_IF - ADDR_W'(1);
        if (fetch.IR[31:28] == OP_JUMP && fetch.IR[27]) rs_q <= rs_data;
      end
      if (fetch.LOAD_happened) flag_q <= 1'b0;
      else if (fire) begin
        pc_temp_q <= target;
        flag_q <= taken;
      end else if (fetch.en && state == RESOLVE) flag_q <= 1'b0;
    end
  assign fetch.PC_temp = pc_temp_q;
  assign fetch.PC_jump_flag = flag_q;
  assign fetch.busy = state != IDLE;
`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      stat_taken <= '0;
      stat_not_taken <= '0;
    end else if (fire) begin
      if (taken && stat_taken != '1) stat_taken <= stat_taken + 32'd1;
      if (!taken && stat_not_taken != '1) stat_not_taken <= stat_not_taken + 32'd1;
    end
`endif
endmodule

// File: tb/tb_cpu_branch_resolve.sv
// tb_cpu_branch_resolve: directed scenario bench for cpu_branch_resolve
module tb_cpu_branch_resolve;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] alu_flags;
  logic [4:0] jr_addr;
  logic [31:0] rs_data;
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_taken, stat_not_taken;
`endif
  int total = 0;
  int bad = 0;
  localparam logic [31:0] BUB = 32'h4000_0000;
  // {cond, flags in EVAL, expected taken}
  localparam logic [8:0] COND_TAB [20] = '{
    {4'd0, 4'b1111, 1'b0}, {4'd1, 4'b0000, 1'b1}, {4'd2, 4'b0000, 1'b0}, {4'd2, 4'b1000, 1'b1},
    {4'd3, 4'b0000, 1'b1}, {4'd3, 4'b1000, 1'b0}, {4'd4, 4'b0100, 1'b1}, {4'd4, 4'b0101, 1'b0},
    {4'd5, 4'b0101, 1'b1}, {4'd5, 4'b0001, 1'b0}, {4'd6, 4'b0010, 1'b1}, {4'd6, 4'b0000, 1'b0},
    {4'd7, 4'b0010, 1'b0}, {4'd7, 4'b0000, 1'b1}, {4'd8, 4'b0100, 1'b1}, {4'd8, 4'b0000, 1'b0},
    {4'd9, 4'b0100, 1'b0}, {4'd9, 4'b0000, 1'b1}, {4'd10, 4'b1111, 1'b0}, {4'd15, 4'b1111, 1'b0}};

  cpu_branch_resolve_if #(.ADDR_W(32)) bif ();

  cpu_branch_resolve #(.ADDR_W(32), .OFF_W(24), .RADDR_W(5)) dut (
    .clk(clk),
    .rst(rst),
    .fetch(bif),
    .alu_flags(alu_flags),
    .jr_addr(jr_addr),
    .rs_data(rs_data)
`ifdef BRANCH_STATS_EN
    ,
    .stat_taken(stat_taken),
    .stat_not_taken(stat_not_taken)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1 rst = 1'b0;
    bif.en = 1'b1; bif.LOAD_happened = 1'b0; bif.IR = '0; bif.PC_IF = '0;
    alu_flags = '0; rs_data = '0;
    step(); step();
    total++; if (bif.PC_jump_flag !== 1'b0) begin bad++; $display("FAIL reset_flag got=%h exp=0", bif.PC_jump_flag); end
    total++; if (bif.PC_temp !== 32'h0) begin bad++; $display("FAIL reset_pc_temp got=%h exp=0", bif.PC_temp); end
    total++; if (bif.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%h exp=0", bif.busy); end
    rst = 1'b1;
    step();
    total++; if (bif.busy !== 1'b0) begin bad++; $display("FAIL reset_idle_busy got=%h exp=0", bif.busy); end
  endtask

  task automatic test_taken();
    step(); bif.IR = 32'h4200_0005; bif.PC_IF = 32'h11; alu_flags = 4'b1000;
    #1;
    total++; if (bif.busy !== 1'b0) begin bad++; $display("FAIL taken_c1_busy got=%h exp=0", bif.busy); end
    total++; if (jr_addr !== 5'd5) begin bad++; $display("FAIL taken_jr_addr got=%h exp=05", jr_addr); end
    step(); bif.IR = BUB; bif.PC_IF = 32'h12;
    total++; if (bif.busy !== 1'b1) begin bad++; $display("FAIL taken_c2_busy got=%h exp=1", bif.busy); end
    total++; if (bif.PC_jump_flag !== 1'b0) begin bad++; $display("FAIL taken_c2_flag got=%h exp=0", bif.PC_jump_flag); end
    step();
    total++; if (bif.PC_jump_flag !== 1'b1) begin bad++; $display("FAIL taken_c3_flag got=%h exp=1", bif.PC_jump_flag); end
    total++; if (bif.PC_temp !== 32'h15) begin bad++; $display("FAIL taken_c3_target got=%h exp=00000015", bif.PC_temp); end
    step(); bif.IR = '0;
    total++; if (bif.PC_jump_flag !== 1'b0) begin bad++; $display("FAIL taken_c4_flag got=%h exp=0", bif.PC_jump_flag); end
    total++; if (bif.busy !== 1'b0) begin bad++; $display("FAIL taken_c4_busy got=%h exp=0", bif.busy); end
    total++; if (bif.PC_temp !== 32'h15) begin bad++; $display("FAIL taken_c4_hold got=%h exp=00000015", bif.PC_temp); end
  endtask

  task automatic test_not_taken();
    step(); bif.IR = 32'h4200_0005; bif.PC_IF = 32'h11; alu_flags = 4'b0000;
    step(); bif.IR = BUB;
    step();
    total++; if (bif.PC_jump_flag !== 1'b0) begin bad++; $display("FAIL nt_c3_flag got=%h exp=0", bif.PC_jump_flag); end
    total++; if (bif.busy !== 1'b1) begin bad++; $display("FAIL nt_c3_busy got=%h exp=1", bif.busy); end
    total++; if (bif.PC_temp !== 32'h15) begin bad++; $display("FAIL nt_c3_target got=%h exp=00000015", bif.PC_temp); end
    step(); bif.IR = '0;
    total++; if (bif.busy !== 1'b0) begin bad++; $display("FAIL nt_c4_busy got=%h exp=0", bif.busy); end
  endtask

  task automatic test_wrap();
    step(); bif.IR = 32'h41FF_FFFE; bif.PC_IF = 32'h1; alu_flags = 4'b0000;
    step(); bif.IR = BUB;
    step();
    total++; if (bif.PC_jump_flag !== 1'b1) begin bad++; $display("FAIL wrap_flag got=%h exp=1", bif.PC_jump_flag); end
    total++; if (bif.PC_temp !== 32'hFFFF_FFFE) begin bad++; $display("FAIL wrap_target got=%h exp=fffffffe", bif.PC_temp); end
    step(); bif.IR = '0;
  endtask

  task automatic test_jump_indirect();
    step(); bif.IR = 32'h5800_0003; bif.PC_IF = 32'h41; rs_data = 32'h2000;
    #1;
    total++; if (jr_addr !== 5'd3) begin bad++; $display("FAIL ji_jr_addr got=%h exp=03", jr_addr); end
    step(); bif.IR = BUB; rs_data = 32'hDEAD_BEEF;
    step();
    total++; if (bif.PC_jump_flag !== 1'b1) begin bad++; $display("FAIL ji_flag got=%h exp=1", bif.PC_jump_flag); end
    total++; if (bif.PC_temp !== 32'h2000) begin bad++; $display("FAIL ji_target got=%h exp=00002000", bif.PC_temp); end
    step(); bif.IR = '0;
    total++; if (bif.busy !== 1'b0) begin bad++; $display("FAIL ji_c4_busy got=%h exp=0", bif.busy); end
    total++; if (bif.PC_jump_flag !== 1'b0) begin bad++; $display("FAIL ji_c4_flag got=%h exp=0", bif.PC_jump_flag); end
    step();
    total++; if (bif.busy !== 1'b0) begin bad++; $display("FAIL ji_no_recapture got=%h exp=0", bif.busy); end
  endtask

  task automatic test_jump_abs();
    step(); bif.IR = 32'h5000_1234; bif.PC_IF = 32'h51; rs_data = 32'hFFFF; alu_flags = 4'b0000;
    step(); bif.IR = BUB;
    step();
    total++; if (bif.PC_jump_flag !== 1'b1) begin bad++; $display("FAIL ja_flag got=%h exp=1", bif.PC_jump_flag); end
    total++; if (bif.PC_temp !== 32'h1234) begin bad++; $display("FAIL ja_target got=%h exp=00001234", bif.PC_temp); end
    step(); bif.IR = '0;
  endtask

  task automatic test_conditions();
    for (int i = 0; i < 20; i++) begin
      logic [8:0] e;
      e = COND_TAB[i];
      step(); bif.IR = {4'b0100, e[8:5], 24'h000008}; bif.PC_IF = 32'h101; alu_flags = ~e[4:1];
      step(); bif.IR = BUB; alu_flags = e[4:1];
      step();
      total++; if (bif.PC_jump_flag !== e[0]) begin bad++; $display("FAIL cond_%0d_flags_%b got=%h exp=%h", e[8:5], e[4:1], bif.PC_jump_flag, e[0]); end
      total++; if (bif.PC_temp !== 32'h108) begin bad++; $display("FAIL cond_%0d_target got=%h exp=00000108", e[8:5], bif.PC_temp); end
      step(); bif.IR = '0;
    end
  endtask

  task automatic test_load_en();
    step(); bif.IR = 32'h4100_0010; bif.PC_IF = 32'h21; alu_flags = 4'b0000;
    step(); bif.LOAD_happened = 1'b1;
    total++; if (bif.busy !== 1'b1) begin bad++; $display("FAIL load_eval_busy got=%h exp=1", bif.busy); end
    step(); bif.LOAD_happened = 1'b0;
    total++; if (bif.busy !== 1'b0) begin bad++; $display("FAIL load_idle_busy got=%h exp=0", bif.busy); end
    total++; if (bif.PC_jump_flag !== 1'b0) begin bad++; $display("FAIL load_idle_flag got=%h exp=0", bif.PC_jump_flag); end
    step(); bif.IR = BUB;
    total++; if (bif.busy !== 1'b1) begin bad++; $display("FAIL load_recapture_busy got=%h exp=1", bif.busy); end
    total++; if (bif.PC_jump_flag !== 1'b0) begin bad++; $display("FAIL load_reeval_flag got=%h exp=0", bif.PC_jump_flag); end
    step();
    total++; if (bif.PC_jump_flag !== 1'b1) begin bad++; $display("FAIL load_resolve_flag got=%h exp=1", bif.PC_jump_flag); end
    total++; if (bif.PC_temp !== 32'h30) begin bad++; $display("FAIL load_resolve_target got=%h exp=00000030", bif.PC_temp); end
    bif.en = 1'b0;
    step();
    total++; if (bif.PC_jump_flag !== 1'b1) begin bad++; $display("FAIL en0_c1_flag got=%h exp=1", bif.PC_jump_flag); end
    total++; if (bif.busy !== 1'b1) begin bad++; $display("FAIL en0_c1_busy got=%h exp=1", bif.busy); end
    step();
    total++; if (bif.PC_jump_flag !== 1'b1) begin bad++; $display("FAIL en0_c2_flag got=%h exp=1", bif.PC_jump_flag); end
    total++; if (bif.PC_temp !== 32'h30) begin bad++; $display("FAIL en0_c2_target got=%h exp=00000030", bif.PC_temp); end
    bif.en = 1'b1;
    step(); bif.IR = '0;
    total++; if (bif.PC_jump_flag !== 1'b0) begin bad++; $display("FAIL en1_release_flag got=%h exp=0", bif.PC_jump_flag); end
    total++; if (bif.busy !== 1'b0) begin bad++; $display("FAIL en1_release_busy got=%h exp=0", bif.busy); end
  endtask

  task automatic test_back_to_back();
    step(); bif.IR = 32'h4100_0004; bif.PC_IF = 32'h201; alu_flags = 4'b0000;
    step(); bif.IR = BUB;
    step();
    total++; if (bif.PC_jump_flag !== 1'b1) begin bad++; $display("FAIL b2b_a_flag got=%h exp=1", bif.PC_jump_flag); end
    total++; if (bif.PC_temp !== 32'h204) begin bad++; $display("FAIL b2b_a_target got=%h exp=00000204", bif.PC_temp); end
    step(); bif.IR = 32'h4200_0002; bif.PC_IF = 32'h301; alu_flags = 4'b1000;
    total++; if (bif.PC_jump_flag !== 1'b0) begin bad++; $display("FAIL b2b_gap_flag got=%h exp=0", bif.PC_jump_flag); end
    total++; if (bif.busy !== 1'b0) begin bad++; $display("FAIL b2b_gap_busy got=%h exp=0", bif.busy); end
    step(); bif.IR = BUB;
    total++; if (bif.busy !== 1'b1) begin bad++; $display("FAIL b2b_b_eval_busy got=%h exp=1", bif.busy); end
    step();
    total++; if (bif.PC_jump_flag !== 1'b1) begin bad++; $display("FAIL b2b_b_flag got=%h exp=1", bif.PC_jump_flag); end
    total++; if (bif.PC_temp !== 32'h302) begin bad++; $display("FAIL b2b_b_target got=%h exp=00000302", bif.PC_temp); end
    step(); bif.IR = '0;
    total++; if (bif.busy !== 1'b0) begin bad++; $display("FAIL b2b_end_busy got=%h exp=0", bif.busy); end
  endtask

  task automatic test_reset_mid();
    step(); bif.IR = 32'h4100_0007; bif.PC_IF = 32'h401; alu_flags = 4'b0000;
    step(); bif.IR = BUB;
    total++; if (bif.busy !== 1'b1) begin bad++; $display("FAIL rmid_eval_busy got=%h exp=1", bif.busy); end
    rst = 1'b0;
    #1;
    total++; if (bif.busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%h exp=0", bif.busy); end
    total++; if (bif.PC_jump_flag !== 1'b0) begin bad++; $display("FAIL rmid_flag got=%h exp=0", bif.PC_jump_flag); end
    total++; if (bif.PC_temp !== 32'h0) begin bad++; $display("FAIL rmid_pc_temp got=%h exp=0", bif.PC_temp); end
`ifdef BRANCH_STATS_EN
    total++; if (stat_taken !== 32'h0) begin bad++; $display("FAIL rmid_stat_taken got=%0d exp=0", stat_taken); end
    total++; if (stat_not_taken !== 32'h0) begin bad++; $display("FAIL rmid_stat_not_taken got=%0d exp=0", stat_not_taken); end
`endif
    step(); rst = 1'b1; bif.IR = '0;
    step();
    total++; if (bif.PC_jump_flag !== 1'b0) begin bad++; $display("FAIL rmid_after_flag got=%h exp=0", bif.PC_jump_flag); end
    total++; if (bif.busy !== 1'b0) begin bad++; $display("FAIL rmid_after_busy got=%h exp=0", bif.busy); end
    step();
    total++; if (bif.PC_temp !== 32'h0) begin bad++; $display("FAIL rmid_after_pc_temp got=%h exp=0", bif.PC_temp); end
  endtask

`ifdef BRANCH_STATS_EN
  task automatic test_stats();
    logic [4:0] pat;
    pat = 5'b01101;
    for (int i = 0; i < 5; i++) begin
      step(); bif.IR = {4'b0100, pat[i] ? 4'd1 : 4'd0, 24'h000001}; bif.PC_IF = 32'h501; alu_flags = 4'b0000;
      step(); bif.IR = BUB;
      step();
      step(); bif.IR = '0;
    end
    step();
    total++; if (stat_taken !== 32'd3) begin bad++; $display("FAIL stats_taken got=%0d exp=3", stat_taken); end
    total++; if (stat_not_taken !== 32'd2) begin bad++; $display("FAIL stats_not_taken got=%0d exp=2", stat_not_taken); end
  endtask
`endif

  initial begin
    test_reset();
    test_taken();
    test_not_taken();
    test_wrap();
    test_jump_indirect();
    test_jump_abs();
    test_conditions();
    test_load_en();
    test_back_to_back();
    test_reset_mid();
`ifdef BRANCH_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
